dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_starve_ctr.sv | 57 +++++
 rtl/dmem_arbiter.sv | 74 +++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared definitions for the data-RAM arbiter
// Purpose: fairness FSM state encoding and default bus widths.
// Ports: none (package).
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    S_NORM  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, EXT and RAM port bundle of the data-RAM arbiter
// Purpose: groups the CPU request, EXT request and RAM signals.
// Ports: slave = arbiter side, master = surrounding pipeline/EXT/RAM side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;
  logic [DATA_W-1:0] ram_do;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  ram_do,
    output cpu_stall, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output ram_we, ram_addr, ram_di
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output ram_do,
    input  cpu_stall, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// rtl/dmem_arbiter_starve_ctr.sv - EXT starvation counter and force FSM
// Purpose: counts consecutive denied EXT cycles and forces one EXT grant
//          once STARVE_MAX is reached.
// Ports: clk, clr (async active-high reset), ext_req_i, ext_gnt_i in;
//        force_o out (EXT owns the RAM this cycle regardless of the CPU).
module dmem_arbiter_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic ext_req_i,
  input  logic ext_gnt_i,
  output logic force_o
);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_NORM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    force_o = 1'b0;
    case (state_q)
      S_NORM: begin
        // A served or withdrawn request ends the run of denials.
        if (!ext_req_i || ext_gnt_i) begin
          cnt_d = '0;
        end else if (cnt_q != MaxCnt) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (ext_req_i && (cnt_d == MaxCnt)) begin
          state_d = S_FORCE;
        end
      end
      S_FORCE: begin
        force_o = 1'b1;
        cnt_d   = '0;
        state_d = S_NORM;
      end
      default: state_d = S_NORM;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter between CPU MEM stage and EXT master
// Purpose: picks the RAM owner each cycle, muxes we/addr/di, stalls the CPU
//          when it loses, and returns read data. Optional fairness build:
//          define DMEM_ARB_FAIRNESS_EN to bound EXT starvation.
// Ports: clk; clr (async active-high reset); bus (dmem_arbiter_if.slave):
//        cpu_* request/stall/rdata, ext_* request/gnt/rvalid/rdata, ram_* port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input logic           clk,
  input logic           clr,
  dmem_arbiter_if.slave bus
);
  logic              force_w;
  logic              cpu_gnt;
  logic              ext_gnt;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_di;

  if (STARVE_MAX >= (1 << CNT_W)) begin : g_bad_cfg
    $error("CNT_W too narrow for STARVE_MAX");
  end

`ifdef DMEM_ARB_FAIRNESS_EN
  dmem_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .clr      (clr),
    .ext_req_i(bus.ext_req),
    .ext_gnt_i(ext_gnt),
    .force_o  (force_w)
  );
`else
  assign force_w = 1'b0;
`endif

  // Grants are masked by clr so the RAM sees no write while reset is held.
  always_comb begin
    cpu_gnt  = bus.cpu_req & ~force_w & ~clr;
    ext_gnt  = bus.ext_req & (~bus.cpu_req | force_w) & ~clr;
    ram_addr = bus.cpu_addr;
    ram_di   = bus.cpu_wdata;
    if (ext_gnt) begin
      ram_addr = bus.ext_addr;
      ram_di   = bus.ext_wdata;
    end
    ext_rvalid_d = ext_gnt & ~bus.ext_we;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_rvalid_q <= 1'b0;
    end else begin
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  assign bus.ram_we     = (cpu_gnt & bus.cpu_we) | (ext_gnt & bus.ext_we);
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_di     = ram_di;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt & ~clr;
  assign bus.cpu_rdata  = bus.ram_do;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = bus.ram_do;
endmodule
